// File: rtl/gumnut_pkg.sv
// gumnut_pkg: shared ALU/writeback-source encodings and default datapath sizing
package gumnut_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDC = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBC = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_MASK = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_ROL  = 4'd10,
        ALU_ROR  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_DATA = 2'd1,
        SRC_PORT = 2'd2,
        SRC_RSV  = 2'd3
    } reg_src_e;

endpackage

// File: rtl/gumnut_regfile.sv
// gumnut_regfile: register file with two async read ports and one sync write port; r0 stays zero
module gumnut_regfile
    import gumnut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [DATA_W-1:0] rda_o,
    output logic [DATA_W-1:0] rdb_o
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            r_regs[wa_i] <= wd_i;
        end
    end

    assign rda_o = r_regs[ra_i];
    assign rdb_o = r_regs[rb_i];

endmodule

// File: rtl/gumnut_dpath_pipe.sv
// gumnut_dpath_pipe: single-E-stage Gumnut datapath with forwarding, load stall, shifter and flag shadow
module gumnut_dpath_pipe
    import gumnut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    localparam int REG_AW = $clog2(NREGS),
    localparam int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ClkEn_i,
    input  logic              dec_vld_i,
    output logic              dec_rdy_o,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              op2_sel_i,
    input  logic [3:0]        alu_op_i,
    input  logic [1:0]        reg_src_i,
    input  logic              reg_wrt_i,
    input  logic              flag_wrt_i,
    input  logic              ext_vld_i,
    input  logic [DATA_W-1:0] data_dat_i,
    input  logic [DATA_W-1:0] port_data_i,
    input  logic              int_i,
    input  logic              reti_i,
    output logic [DATA_W-1:0] res_o,
    output logic              res_vld_o,
    output logic              ccC_o,
    output logic              ccZ_o
);

    logic                r_e_vld, r_e_rwr, r_e_fwr;
    logic [DATA_W-1:0]   r_e_a, r_e_b, r_res;
    logic [REG_AW-1:0]   r_e_rd;
    logic [CNT_W-1:0]    r_e_cnt;
    alu_op_e             r_e_op;
    reg_src_e            r_e_src;
    logic                r_c, r_z, r_sc, r_sz, r_res_vld;
    logic [DATA_W-1:0]   w_rf_a, w_rf_b, w_op_a, w_op_b, w_res, w_wb;
    logic [DATA_W:0]     w_add, w_sub, w_shl, w_shr;
    logic [2*DATA_W-1:0] w_rol, w_ror;
    logic                w_stall, w_commit, w_issue, w_fwd, w_cin, w_c, w_c_nx, w_z_nx;

    assign w_stall   = r_e_vld & (r_e_src == SRC_DATA || r_e_src == SRC_PORT) & ~ext_vld_i;
    assign dec_rdy_o = ~w_stall;
    assign w_commit  = ClkEn_i & r_e_vld & ~w_stall;
    assign w_issue   = ClkEn_i & dec_vld_i & ~w_stall;
    // rd != 0 keeps r0 out of the bypass path
    assign w_fwd     = w_commit & r_e_rwr & (r_e_rd != '0);
    assign w_op_a    = (w_fwd && rs_i == r_e_rd) ? w_wb : w_rf_a;
    assign w_op_b    = op2_sel_i ? immed_i : (w_fwd && rs2_i == r_e_rd) ? w_wb : w_rf_b;

    assign w_cin = (r_e_op == ALU_ADDC || r_e_op == ALU_SUBC) & r_c;
    assign w_add = {1'b0, r_e_a} + {1'b0, r_e_b} + {{DATA_W{1'b0}}, w_cin};
    assign w_sub = {1'b0, r_e_a} - {1'b0, r_e_b} - {{DATA_W{1'b0}}, w_cin};
    assign w_shl = {1'b0, r_e_a} << r_e_cnt;
    assign w_shr = {r_e_a, 1'b0} >> r_e_cnt;
    assign w_rol = {r_e_a, r_e_a} << r_e_cnt;
    assign w_ror = {r_e_a, r_e_a} >> r_e_cnt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (r_e_op)
            ALU_ADD, ALU_ADDC: {w_c, w_res} = w_add;
            ALU_SUB, ALU_SUBC: {w_c, w_res} = w_sub;
            ALU_AND:  w_res = r_e_a & r_e_b;
            ALU_OR:   w_res = r_e_a | r_e_b;
            ALU_XOR:  w_res = r_e_a ^ r_e_b;
            ALU_MASK: w_res = r_e_a & ~r_e_b;
            ALU_SHL:  {w_c, w_res} = w_shl;
            ALU_SHR:  {w_res, w_c} = w_shr;
            ALU_ROL: begin
                w_res = w_rol[2*DATA_W-1:DATA_W];
                w_c   = (|r_e_cnt) & w_res[0];
            end
            ALU_ROR: begin
                w_res = w_ror[DATA_W-1:0];
                w_c   = (|r_e_cnt) & w_res[DATA_W-1];
            end
            default: ;
        endcase
    end

    assign w_wb = r_e_src == SRC_DATA ? data_dat_i : r_e_src == SRC_PORT ? port_data_i : w_res;
    // reti restores before int captures, so int&reti shadows the restored flags
    assign w_c_nx = reti_i ? r_sc : (w_commit & r_e_fwr) ? w_c : r_c;
    assign w_z_nx = reti_i ? r_sz : (w_commit & r_e_fwr) ? (w_wb == '0) : r_z;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_e_vld   <= 1'b0;
            r_e_rwr   <= 1'b0;
            r_e_fwr   <= 1'b0;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_e_rd    <= '0;
            r_e_cnt   <= '0;
            r_e_op    <= ALU_ADD;
            r_e_src   <= SRC_ALU;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_sc      <= 1'b0;
            r_sz      <= 1'b0;
        end else begin
            r_res_vld <= w_commit;
            if (w_commit) r_res <= w_wb;
            if (ClkEn_i) begin
                r_c <= w_c_nx;
                r_z <= w_z_nx;
                if (int_i) begin
                    r_sc <= w_c_nx;
                    r_sz <= w_z_nx;
                end
                if (w_issue) begin
                    r_e_vld <= 1'b1;
                    r_e_rwr <= reg_wrt_i;
                    r_e_fwr <= flag_wrt_i;
                    r_e_a   <= w_op_a;
                    r_e_b   <= w_op_b;
                    r_e_rd  <= rd_i;
                    r_e_cnt <= count_i;
                    r_e_op  <= alu_op_e'(alu_op_i);
                    r_e_src <= reg_src_e'(reg_src_i);
                end else if (w_commit) begin
                    r_e_vld <= 1'b0;
                end
            end
        end
    end

    gumnut_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we_i  (w_commit & r_e_rwr),
        .wa_i  (r_e_rd),
        .wd_i  (w_wb),
        .ra_i  (rs_i),
        .rb_i  (rs2_i),
        .rda_o (w_rf_a),
        .rdb_o (w_rf_b)
    );

    assign res_o     = r_res;
    assign res_vld_o = r_res_vld;
    assign ccC_o     = r_c;
    assign ccZ_o     = r_z;

endmodule
